// File: rtl/core_mem_arbiter.sv
// Purpose : arbitrates instruction-fetch and data requests onto one shared memory port.
// Latency : store ACK 2 cycles after REQ is sampled, read ACK 2+MEM_LAT cycles after.
// Backpres: requesters hold REQ until ACK; requests are ignored while BUSY.
//
// Ports:
//   CLK, RST_N                    clock, asynchronous active-low reset
//   I_REQ/I_ADDR -> I_ACK/I_RDATA fetch side (read only)
//   D_REQ/D_WE/D_BE/D_ADDR/D_WDATA -> D_ACK/D_RDATA   load/store side
//   M_ADDR/M_WDATA/M_BE/M_WE/M_RE, M_RDATA            shared memory port
//   BUSY                          high whenever a transaction is in flight
// Parameter MEM_LAT (1..4): memory read latency from the M_RE cycle to valid M_RDATA.
// Optional macro CORE_MEM_ARB_RR_EN: round-robin arbitration on simultaneous
// requests (default build: data has fixed priority over fetch).

module core_mem_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        I_REQ,
   input  logic [31:0] I_ADDR,
   output logic        I_ACK,
   output logic [31:0] I_RDATA,
   input  logic        D_REQ,
   input  logic        D_WE,
   input  logic [3:0]  D_BE,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   output logic        D_ACK,
   output logic [31:0] D_RDATA,
   output logic [31:0] M_ADDR,
   output logic [31:0] M_WDATA,
   output logic [3:0]  M_BE,
   output logic        M_WE,
   output logic        M_RE,
   input  logic [31:0] M_RDATA,
   output logic        BUSY
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  cnt_q;
   logic        cnt_done;
   logic        any_req;
   logic        pick_d;
   logic        gnt_d_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;

   assign any_req  = I_REQ | D_REQ;
   // Last WAIT cycle is the one exactly MEM_LAT cycles after ACCESS.
   assign cnt_done = (cnt_q == 3'(MEM_LAT - 1));

`ifdef CORE_MEM_ARB_RR_EN
   // Last-grant flag: 1 = data, 0 = fetch. Resets to fetch so data wins first.
   logic last_d_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         last_d_q <= 1'b0;
      else if (state_q == IDLE && any_req)
         last_d_q <= pick_d;
   end

   // On a contest the side not granted last wins; lone requests pass through.
   assign pick_d = D_REQ & (~I_REQ | ~last_d_q);
`else
   // Data wins whenever it is requesting.
   assign pick_d = D_REQ;
`endif

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = we_q ? RESP : WAIT;
         WAIT:    if (cnt_done) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      I_ACK = 1'b0;
      D_ACK = 1'b0;
      M_RE  = 1'b0;
      M_WE  = 1'b0;
      BUSY  = (state_q != IDLE);
      case (state_q)
         ACCESS: begin
            M_RE = ~we_q;
            M_WE = we_q;
         end
         RESP: begin
            I_ACK = ~gnt_d_q;
            D_ACK = gnt_d_q;
         end
         default: ;
      endcase
   end

   // Request latch, taken on the IDLE edge that accepts a request.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gnt_d_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
      end else if (state_q == IDLE && any_req) begin
         gnt_d_q <= pick_d;
         we_q    <= pick_d & D_WE;
         addr_q  <= pick_d ? D_ADDR : I_ADDR;
         wdata_q <= pick_d ? D_WDATA : 32'h0;
         // Fetches read the whole word.
         be_q    <= pick_d ? D_BE : 4'hF;
      end
   end

   // Wait counter: restarts at zero on every entry into WAIT.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         cnt_q <= 3'd0;
      else if (state_q == WAIT)
         cnt_q <= cnt_q + 3'd1;
      else
         cnt_q <= 3'd0;
   end

   // Read-data capture; each side keeps its last word between ACKs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         i_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
      end else if (state_q == WAIT && cnt_done) begin
         if (gnt_d_q)
            d_rdata_q <= M_RDATA;
         else
            i_rdata_q <= M_RDATA;
      end
   end

   assign I_RDATA = i_rdata_q;
   assign D_RDATA = d_rdata_q;
   assign M_ADDR  = addr_q;
   assign M_WDATA = wdata_q;
   assign M_BE    = be_q;

endmodule
